// File: rtl/spi_flash_pkg.sv
// Shared SPI flash definitions: opcodes, responder states, status layout.
// Also consumed by the AXI-to-SPI initiator.
package spi_flash_pkg;

   localparam logic [7:0] OP_PP     = 8'h02;
   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_WRDI   = 8'h04;
   localparam logic [7:0] OP_RDSR   = 8'h05;
   localparam logic [7:0] OP_WREN   = 8'h06;
   localparam logic [7:0] OP_RST_EN = 8'h66;
   localparam logic [7:0] OP_RST    = 8'h99;

   localparam int STAT_WIP = 0;
   localparam int STAT_WEL = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD_DATA,
      ST_PP_DATA,
      ST_STAT_OUT,
      ST_IGNORE
   } flash_state_t;

   typedef struct packed {
      logic sck_rise;
      logic sck_fall;
      logic cs_fall;
      logic cs_rise;
      logic csn;
      logic mosi;
   } spi_evt_t;

   // No internal program cycle is modelled, so WIP is always 0.
   function automatic logic [7:0] status_byte(input logic wel);
      logic [7:0] s;
      s           = '0;
      s[STAT_WEL] = wel;
      s[STAT_WIP] = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes SCK/CSn/MOSI into clk and flags SCK and CSn edges.
module spi_sync_edge
   import spi_flash_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     sck,
   input  logic     csn,
   input  logic     mosi,
   output spi_evt_t evt
);

   // One extra flop on SCK/CSn holds the previous synchronized sample.
   logic [SYNC_STAGES:0]   sck_q;
   logic [SYNC_STAGES:0]   csn_q;
   logic [SYNC_STAGES-1:0] mosi_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q  <= '0;
         csn_q  <= '1;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[SYNC_STAGES-1:0], sck};
         csn_q  <= {csn_q[SYNC_STAGES-1:0], csn};
         mosi_q <= (mosi_q << 1) | SYNC_STAGES'(mosi);
      end
   end

   assign evt.sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
   assign evt.sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
   assign evt.cs_fall  = ~csn_q[SYNC_STAGES-1] & csn_q[SYNC_STAGES];
   assign evt.cs_rise  = csn_q[SYNC_STAGES-1] & ~csn_q[SYNC_STAGES];
   assign evt.csn      = csn_q[SYNC_STAGES-1];
   assign evt.mosi     = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: read, page program, status, write-enable
// latch and two-step soft reset, fronting a simple byte-wide store.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int ADDR_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SCK,
   input  logic                 CSn,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic                 miso_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_rd_en,
   input  logic [7:0]           mem_rdata,
   output logic                 mem_wr_en,
   output logic [7:0]           mem_wdata,
   output logic                 busy
);

   localparam int ACW = (ADDR_BITS > 1) ? $clog2(ADDR_BITS) : 1;

   spi_evt_t     evt;
   flash_state_t state;
   logic [2:0]   bit_cnt;
   logic [2:0]   out_cnt;
   logic [ACW-1:0] addr_cnt;
   logic [7:0]   shift_in;
   logic [7:0]   miso_sr;
   logic [7:0]   nxt_buf;
   logic         rd_wait;
   logic         wel;
   logic         armed;
   logic         is_pp;
   logic         wrote;
   logic [7:0]   in_byte;
   logic [7:0]   rd_byte;
   logic [7:0]   ld_byte;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .sck  (SCK),
      .csn  (CSn),
      .mosi (MOSI),
      .evt  (evt)
   );

   assign busy    = ~evt.csn;
   assign in_byte = {shift_in[6:0], evt.mosi};
   // At the fastest SCK the first byte arrives in the same cycle as the
   // falling edge that must present it, so bypass the buffer then.
   assign rd_byte = rd_wait ? mem_rdata : nxt_buf;
   assign ld_byte = (state == ST_RD_DATA) ? rd_byte : status_byte(wel);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         out_cnt   <= '0;
         addr_cnt  <= '0;
         shift_in  <= '0;
         miso_sr   <= '0;
         nxt_buf   <= '0;
         rd_wait   <= 1'b0;
         wel       <= 1'b0;
         armed     <= 1'b0;
         is_pp     <= 1'b0;
         wrote     <= 1'b0;
         MISO      <= 1'b0;
         miso_oe   <= 1'b0;
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         mem_wdata <= '0;
      end else begin
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         rd_wait   <= mem_rd_en;
         if (rd_wait)
            nxt_buf <= mem_rdata;
         // Page program advances only within the 256-byte page.
         if (mem_wr_en) begin
            mem_addr[7:0] <= mem_addr[7:0] + 8'd1;
            wrote         <= 1'b1;
         end

         if (evt.cs_rise) begin
            if (state == ST_PP_DATA && (wrote || mem_wr_en))
               wel <= 1'b0;
            state   <= ST_IDLE;
            MISO    <= 1'b0;
            miso_oe <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (evt.cs_fall) begin
                     state   <= ST_CMD;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (evt.sck_rise) begin
                     shift_in <= in_byte;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        armed    <= (in_byte == OP_RST_EN);
                        addr_cnt <= '0;
                        out_cnt  <= '0;
                        wrote    <= 1'b0;
                        state    <= ST_IGNORE;
                        case (in_byte)
                           OP_READ: begin
                              state <= ST_ADDR;
                              is_pp <= 1'b0;
                           end
                           OP_PP: begin
                              if (wel) begin
                                 state <= ST_ADDR;
                                 is_pp <= 1'b1;
                              end
                           end
                           OP_RDSR: state <= ST_STAT_OUT;
                           OP_WREN: wel <= 1'b1;
                           OP_WRDI: wel <= 1'b0;
                           OP_RST:  if (armed) wel <= 1'b0;
                           default: ;
                        endcase
                     end
                  end
               end
               ST_ADDR: begin
                  if (evt.sck_rise) begin
                     mem_addr <= {mem_addr[ADDR_BITS-2:0], evt.mosi};
                     addr_cnt <= addr_cnt + ACW'(1);
                     if (addr_cnt == ACW'(ADDR_BITS - 1)) begin
                        if (is_pp) begin
                           state   <= ST_PP_DATA;
                           bit_cnt <= '0;
                        end else begin
                           state     <= ST_RD_DATA;
                           mem_rd_en <= 1'b1;
                        end
                     end
                  end
               end
               ST_RD_DATA, ST_STAT_OUT: begin
                  if (evt.sck_fall) begin
                     miso_oe <= 1'b1;
                     out_cnt <= out_cnt + 3'd1;
                     if (out_cnt == 3'd0) begin
                        MISO    <= ld_byte[7];
                        miso_sr <= {ld_byte[6:0], 1'b0};
                        // Prefetch the following byte as soon as this one is taken.
                        if (state == ST_RD_DATA) begin
                           mem_rd_en <= 1'b1;
                           mem_addr  <= mem_addr + ADDR_BITS'(1);
                        end
                     end else begin
                        MISO    <= miso_sr[7];
                        miso_sr <= {miso_sr[6:0], 1'b0};
                     end
                  end
               end
               ST_PP_DATA: begin
                  if (evt.sck_rise) begin
                     shift_in <= in_byte;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        mem_wr_en <= 1'b1;
                        mem_wdata <= in_byte;
                     end
                  end
               end
               ST_IGNORE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: clk/4 mode-0 initiator, sparse memory model and a
// flag-level reference model of WEL / reset-arm behaviour.
module tb_spi_flash_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        csn = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        miso_oe;
   logic [23:0] mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_wr_en;
   logic [7:0]  mem_wdata;
   logic        busy;

   typedef struct {
      int unsigned a;
      logic [7:0]  d;
   } wr_t;

   logic [7:0]  mem [int unsigned];
   int unsigned rd_log[$];
   wr_t         wr_log[$];
   bit          both_seen = 1'b0;
   bit          model_wel = 1'b0;
   bit          model_armed = 1'b0;
   int          checks = 0;
   int          failures = 0;

   spi_flash_responder #(.ADDR_BITS(24), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .SCK       (sck),
      .CSn       (csn),
      .MOSI      (mosi),
      .MISO      (miso),
      .miso_oe   (miso_oe),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Backing store: read data is valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         rd_log.push_back(int'(mem_addr));
         mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
      end
      if (mem_wr_en) begin
         wr_log.push_back('{a: int'(mem_addr), d: mem_wdata});
         mem[int'(mem_addr)] = mem_wdata;
      end
      if (mem_rd_en && mem_wr_en)
         both_seen = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One mode-0 SCK period per bit; MISO is sampled late in the high phase.
   task automatic xfer_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         sck  = 1'b0;
         mosi = tx[i];
         tick(); tick();
         sck = 1'b1;
         tick(); tick();
         rx[i] = miso;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      logic [31:0] r;
      xfer_bits({24'h0, tx}, 8, r);
      rx = r[7:0];
   endtask

   task automatic cs_begin();
      csn = 1'b0;
      repeat (4) tick();
   endtask

   task automatic cs_end();
      sck = 1'b0;
      tick(); tick();
      csn = 1'b1;
      repeat (6) tick();
   endtask

   function automatic void model_cmd(input logic [7:0] op);
      if (op == 8'h06) model_wel = 1'b1;
      if (op == 8'h04) model_wel = 1'b0;
      if (op == 8'h99 && model_armed) model_wel = 1'b0;
      model_armed = (op == 8'h66);
   endfunction

   task automatic send_cmd(input logic [7:0] op);
      logic [7:0] r;
      cs_begin();
      xfer(op, r);
      cs_end();
      model_cmd(op);
   endtask

   task automatic read_status(output logic [7:0] st);
      logic [7:0] r;
      cs_begin();
      xfer(8'h05, r);
      xfer(8'h00, st);
      cs_end();
      model_cmd(8'h05);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({miso, miso_oe, mem_rd_en, mem_wr_en, busy} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000", {miso, miso_oe, mem_rd_en, mem_wr_en, busy});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus got=%h exp=00000000", {mem_addr, mem_wdata});
      end
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      model_wel = 1'b0;
      model_armed = 1'b0;
   endtask

   task automatic test_read();
      logic [7:0] r, b0, b1;
      mem[32'h100] = 8'hA5;
      mem[32'h101] = 8'h3C;
      rd_log.delete();
      cs_begin();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL read_busy got=%b exp=1", busy);
      end
      xfer(8'h03, r); xfer(8'h00, r); xfer(8'h01, r); xfer(8'h00, r);
      xfer(8'h00, b0);
      xfer(8'h00, b1);
      checks++;
      if (miso_oe !== 1'b1) begin
         failures++;
         $display("FAIL read_oe got=%b exp=1", miso_oe);
      end
      cs_end();
      model_cmd(8'h03);
      checks++;
      if ({b0, b1} !== 16'hA53C) begin
         failures++;
         $display("FAIL read_data got=%h exp=a53c", {b0, b1});
      end
      checks++;
      if (rd_log.size() < 2 || rd_log[0] != 32'h100 || rd_log[1] != 32'h101) begin
         failures++;
         $display("FAIL read_addr got_n=%0d first=%h exp=100,101", rd_log.size(),
                  (rd_log.size() > 0) ? rd_log[0] : 0);
      end
      checks++;
      if ({miso_oe, busy} !== 2'b00) begin
         failures++;
         $display("FAIL read_end got=%b exp=00", {miso_oe, busy});
      end
   endtask

   task automatic test_program();
      logic [7:0] r, st;
      logic [31:0] exp_a [3] = '{32'h1FE, 32'h1FF, 32'h100};
      logic [7:0]  exp_d [3] = '{8'hDE, 8'hAD, 8'hBE};
      send_cmd(8'h06);
      wr_log.delete();
      cs_begin();
      xfer(8'h02, r); xfer(8'h00, r); xfer(8'h01, r); xfer(8'hFE, r);
      xfer(8'hDE, r); xfer(8'hAD, r); xfer(8'hBE, r);
      cs_end();
      model_cmd(8'h02);
      model_wel = 1'b0;
      checks++;
      if (wr_log.size() != 3) begin
         failures++;
         $display("FAIL pp_count got=%0d exp=3", wr_log.size());
      end
      for (int k = 0; k < 3 && k < wr_log.size(); k++) begin
         checks++;
         if (wr_log[k].a != exp_a[k] || wr_log[k].d !== exp_d[k]) begin
            failures++;
            $display("FAIL pp_write%0d got=%h@%h exp=%h@%h", k, wr_log[k].d, wr_log[k].a, exp_d[k], exp_a[k]);
         end
      end
      read_status(st);
      checks++;
      if (st !== 8'h00) begin
         failures++;
         $display("FAIL pp_wel_clear got=%h exp=00", st);
      end
   endtask

   task automatic test_no_wel();
      logic [7:0] r, st;
      wr_log.delete();
      cs_begin();
      xfer(8'h02, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h11, r);
      cs_end();
      model_cmd(8'h02);
      checks++;
      if (wr_log.size() != 0) begin
         failures++;
         $display("FAIL nowel_write got=%0d exp=0", wr_log.size());
      end
      read_status(st);
      checks++;
      if (st !== 8'h00) begin
         failures++;
         $display("FAIL nowel_status got=%h exp=00", st);
      end
   endtask

   task automatic test_wel();
      logic [7:0] st, r;
      send_cmd(8'h06);
      read_status(st);
      checks++;
      if (st !== 8'h02) begin
         failures++;
         $display("FAIL wren_status got=%h exp=02", st);
      end
      // Trailing bits after a one-byte command are ignored with MISO quiet.
      cs_begin();
      xfer(8'h04, r);
      xfer(8'($urandom), r);
      checks++;
      if ({r, miso_oe} !== 9'h0) begin
         failures++;
         $display("FAIL ignore_quiet got=%h/%b exp=00/0", r, miso_oe);
      end
      cs_end();
      model_cmd(8'h04);
      read_status(st);
      checks++;
      if (st !== 8'h00) begin
         failures++;
         $display("FAIL wrdi_status got=%h exp=00", st);
      end
   endtask

   task automatic test_soft_reset();
      logic [7:0] st;
      send_cmd(8'h06); send_cmd(8'h66); send_cmd(8'h99);
      read_status(st);
      checks++;
      if (st !== 8'h00) begin
         failures++;
         $display("FAIL softrst_armed got=%h exp=00", st);
      end
      send_cmd(8'h06); send_cmd(8'h99);
      read_status(st);
      checks++;
      if (st !== 8'h02) begin
         failures++;
         $display("FAIL softrst_unarmed got=%h exp=02", st);
      end
   endtask

   task automatic test_random_cmds();
      logic [7:0] ops [5] = '{8'h06, 8'h04, 8'h66, 8'h99, 8'hA7};
      logic [7:0] st, exp_st;
      for (int it = 0; it < 10; it++) begin
         for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            send_cmd(ops[$urandom_range(0, 4)]);
         exp_st = model_wel ? 8'h02 : 8'h00;
         read_status(st);
         checks++;
         if (st !== exp_st) begin
            failures++;
            $display("FAIL rand_status%0d got=%h exp=%h", it, st, exp_st);
         end
      end
   endtask

   task automatic test_random_read();
      logic [7:0]  r, got, expd [4];
      logic [23:0] base;
      int          n;
      for (int it = 0; it < 4; it++) begin
         base = (it == 0) ? 24'hFFFFFE : 24'($urandom);
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            expd[k] = 8'($urandom);
            mem[int'(24'(base + 24'(k)))] = expd[k];
         end
         rd_log.delete();
         cs_begin();
         xfer(8'h03, r); xfer(base[23:16], r); xfer(base[15:8], r); xfer(base[7:0], r);
         for (int k = 0; k < n; k++) begin
            xfer(8'($urandom), got);
            checks++;
            if (got !== expd[k]) begin
               failures++;
               $display("FAIL rand_read%0d_%0d got=%h exp=%h", it, k, got, expd[k]);
            end
         end
         cs_end();
         model_cmd(8'h03);
         checks++;
         if (rd_log.size() < n) begin
            failures++;
            $display("FAIL rand_rdcount%0d got=%0d exp>=%0d", it, rd_log.size(), n);
         end
         for (int k = 0; k < rd_log.size(); k++) begin
            checks++;
            if (rd_log[k] != int'(24'(base + 24'(k)))) begin
               failures++;
               $display("FAIL rand_rdaddr%0d_%0d got=%h exp=%h", it, k, rd_log[k], 24'(base + 24'(k)));
            end
         end
      end
   endtask

   task automatic test_random_program();
      logic [7:0]  r, st, d [4];
      logic [23:0] a, ea;
      int          n;
      for (int it = 0; it < 3; it++) begin
         a = 24'($urandom);
         if (it == 0) a[7:0] = 8'hFD;
         n = $urandom_range(1, 4);
         send_cmd(8'h06);
         wr_log.delete();
         cs_begin();
         xfer(8'h02, r); xfer(a[23:16], r); xfer(a[15:8], r); xfer(a[7:0], r);
         for (int k = 0; k < n; k++) begin
            d[k] = 8'($urandom);
            xfer(d[k], r);
         end
         cs_end();
         model_cmd(8'h02);
         model_wel = 1'b0;
         checks++;
         if (wr_log.size() != n) begin
            failures++;
            $display("FAIL rand_pp_count%0d got=%0d exp=%0d", it, wr_log.size(), n);
         end
         for (int k = 0; k < n && k < wr_log.size(); k++) begin
            ea = {a[23:8], 8'(a[7:0] + 8'(k))};
            checks++;
            if (wr_log[k].a != int'(ea) || wr_log[k].d !== d[k]) begin
               failures++;
               $display("FAIL rand_pp%0d_%0d got=%h@%h exp=%h@%h", it, k, wr_log[k].d, wr_log[k].a, d[k], ea);
            end
         end
         read_status(st);
         checks++;
         if (st !== 8'h00) begin
            failures++;
            $display("FAIL rand_pp_wel%0d got=%h exp=00", it, st);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rr;
      logic [7:0]  st;
      int          cut [2] = '{12, 36};
      for (int it = 0; it < 2; it++) begin
         send_cmd(8'h06);
         wr_log.delete();
         rd_log.delete();
         cs_begin();
         xfer_bits(32'h02000040, 32, rr);
         if (cut[it] > 32) xfer_bits(32'h0000000B, cut[it] - 32, rr);
         else begin
            // Restart so that exactly cut[it] bits have been sent.
            cs_end();
            cs_begin();
            xfer_bits(32'h00000020, cut[it], rr);
         end
         rst = 1'b1;
         sck = 1'b0;
         csn = 1'b1;
         tick(); tick();
         checks++;
         if ({miso, miso_oe, mem_rd_en, mem_wr_en, busy, mem_addr, mem_wdata} !== 37'h0) begin
            failures++;
            $display("FAIL midrst_outputs%0d got=%h exp=0", it,
                     {miso, miso_oe, mem_rd_en, mem_wr_en, busy, mem_addr, mem_wdata});
         end
         rst = 1'b0;
         model_wel = 1'b0;
         model_armed = 1'b0;
         tick();
         xfer_bits(32'($urandom), 8, rr);
         sck = 1'b0;
         repeat (4) tick();
         checks++;
         if (wr_log.size() != 0 || rd_log.size() != 0 || miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet%0d got=wr%0d rd%0d oe%b exp=wr0 rd0 oe0", it,
                     wr_log.size(), rd_log.size(), miso_oe);
         end
         read_status(st);
         checks++;
         if (st !== 8'h00) begin
            failures++;
            $display("FAIL midrst_status%0d got=%h exp=00", it, st);
         end
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_seen !== 1'b0) begin
         failures++;
         $display("FAIL strobe_overlap got=%b exp=0", both_seen);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_program();
      test_no_wel();
      test_wel();
      test_soft_reset();
      test_random_cmds();
      test_random_read();
      test_random_program();
      test_reset_mid();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24, giving the byte-address width of the flash address phase and mem_addr.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on SCK, CSn and MOSI.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- SCK  in  1  SPI clock from initiator, mode 0, at most clk/4
- CSn  in  1  chip select, active low
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first
- miso_oe  out  1  MISO output enable, high only while shifting read or status data
- mem_addr  out  ADDR_BITS  byte address to backing store
- mem_rd_en  out  1  one-cycle read strobe
- mem_rdata  in  8  read data, valid exactly one clk after mem_rd_en
- mem_wr_en  out  1  one-cycle write strobe
- mem_wdata  out  8  write byte, qualified by mem_wr_en
- busy  out  1  high whenever CSn (synchronized) is low

Function
REQ-004 SHALL synchronize SCK, CSn and MOSI through SYNC_STAGES flops, then detect SCK rising/falling edges from the last two synchronized samples.
REQ-005 SHALL sample MOSI on detected SCK rising edges and update MISO on detected SCK falling edges.
REQ-006 SHALL implement states IDLE, CMD, ADDR, RD_DATA, PP_DATA, STAT_OUT, IGNORE.
REQ-007 SHALL go IDLE->CMD on synchronized CSn falling edge, clearing the bit counter to 0.
REQ-008 SHALL, in any state, return to IDLE on synchronized CSn rising edge, drop miso_oe the same cycle, and discard any partial byte.
REQ-009 SHALL decode the command after the 8th rising edge: 0x03 -> ADDR (read), 0x02 -> ADDR (program) only if WEL=1 else IGNORE, 0x05 -> STAT_OUT, 0x06 -> set WEL then IGNORE, 0x04 -> clear WEL then IGNORE, 0x66 -> arm reset then IGNORE, 0x99 -> if armed perform soft reset then IGNORE, any other -> IGNORE.
REQ-010 SHALL clear the reset-armed flag on any command other than 0x66; soft reset clears WEL and the armed flag only.
REQ-011 SHALL collect ADDR_BITS address bits MSB first in ADDR.
REQ-012 SHALL, on read, pulse mem_rd_en with the address in the cycle after the last address bit and load the returned byte into the MISO shift register before the next SCK falling edge; MISO shows bit 7 at that falling edge.
REQ-013 SHALL prefetch the next byte (address+1) immediately after each byte is loaded, so continuous reads have no gap; read address wraps modulo 2^ADDR_BITS.
REQ-014 SHALL, in PP_DATA, on every 8th rising edge pulse mem_wr_en for one clk with the assembled byte and current address, then increment only address[7:0] (wrap within 256-byte page, upper bits unchanged).
REQ-015 SHALL clear WEL at CSn rising edge ending a program command that wrote at least one byte.
REQ-016 SHALL shift status byte {6'b0, WEL, WIP} repeatedly in STAT_OUT; WIP always reads 0.
REQ-017 SHALL ignore all further MOSI bits in IGNORE; MISO held 0, miso_oe low.
REQ-018 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.

Reset
REQ-019 SHALL on rst: state IDLE, WEL 0, armed 0, MISO 0, miso_oe 0, mem_rd_en 0, mem_wr_en 0, mem_addr 0, mem_wdata 0, busy 0, synchronizers to CSn=1/SCK=0/MOSI=0.
REQ-020 SHALL, on rst assertion mid-transaction, abort with no further mem strobes and remain IDLE until a fresh CSn falling edge after rst deasserts.

Structure
REQ-021 SHALL place command opcodes (0x03,0x02,0x05,0x06,0x04,0x66,0x99), state enum and status bit positions in a shared package spi_flash_pkg, also used by the AXI-to-SPI initiator.
REQ-022 SHALL use one sub-module, spi_sync_edge, for synchronizer plus edge detection.

Verification
REQ-023 Bench SHALL drive SCK = clk/4 mode 0 and cover:
- mem preloaded 0x000100=0xA5, 0x000101=0x3C; send 03 000100, clock 16 bits -> MISO bytes A5,3C; mem_rd_en pulses at 0x100,0x101.
- send 06, CSn high, then 02 0001FE DE AD BE -> writes DE@0x1FE, AD@0x1FF, BE@0x100 (page wrap); next 05 reads 0x00.
- send 02 000000 11 without prior 06 -> no mem_wr_en; 05 reads 0x00.
- send 06 then 05 -> status 0x02; send 04 then 05 -> 0x00.
- 06; 66; 99; 05 -> 0x00; 06; 99 (not armed); 05 -> 0x02.
- rst asserted after 12 data bits of program -> no mem_wr_en, all outputs at reset values.
